// File: rtl/apb_cmd_master_if.sv
// Bundles the command, response and APB signals of apb_cmd_master.
// The master modport is the initiator's view; slave is the environment's view.
interface apb_cmd_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [STRB_W-1:0] cmd_wstrb;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_slverr;
    logic              rsp_timeout;

    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [STRB_W-1:0] pstrb;
    logic              pready;
    logic [DATA_W-1:0] prdata;
    logic              pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
        input  rsp_ready,
        output paddr, psel, penable, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
        output rsp_ready,
        input  paddr, psel, penable, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_cmd_master.sv
// APB4 initiator: one valid/ready command becomes one APB transfer, whose
// result is returned on a valid/ready response stream, with a wait-state timeout.
module apb_cmd_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               pclk,
    input  logic               presetn,
    apb_cmd_master_if.master   bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam bit               TO_EN    = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [STRB_W-1:0] pstrb_q, pstrb_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_slverr_q, rsp_slverr_d;
    logic              rsp_timeout_q, rsp_timeout_d;

    // Wait-state counter saturates so a disabled timeout can never wrap into a false abort.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_W'(1));

    // Next-state and next-output logic for the transfer FSM.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        paddr_d       = paddr_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_slverr_d  = rsp_slverr_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    state_d   = SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    paddr_d   = bus.cmd_addr;
                    pwrite_d  = bus.cmd_write;
                    pwdata_d  = bus.cmd_write ? bus.cmd_wdata : {DATA_W{1'b0}};
                    pstrb_d   = bus.cmd_write ? bus.cmd_wstrb : {STRB_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (bus.pready) begin
                    state_d       = RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite_q ? {DATA_W{1'b0}} : bus.prdata;
                    rsp_slverr_d  = bus.pslverr;
                    rsp_timeout_d = 1'b0;
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    state_d       = RESP;
                    cnt_d         = cnt_inc;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = {DATA_W{1'b0}};
                    rsp_slverr_d  = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d       = IDLE;
                    cnt_d         = {CNT_W{1'b0}};
                    rsp_valid_d   = 1'b0;
                    rsp_slverr_d  = 1'b0;
                    rsp_timeout_d = 1'b0;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d     = IDLE;
                psel_d      = 1'b0;
                penable_d   = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State, counter and registered bus/response outputs.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q       <= IDLE;
            cnt_q         <= {CNT_W{1'b0}};
            paddr_q       <= {ADDR_W{1'b0}};
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= {DATA_W{1'b0}};
            pstrb_q       <= {STRB_W{1'b0}};
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= {DATA_W{1'b0}};
            rsp_slverr_q  <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            paddr_q       <= paddr_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_slverr_q  <= rsp_slverr_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign bus.cmd_ready   = (state_q == IDLE);
    assign bus.paddr       = paddr_q;
    assign bus.psel        = psel_q;
    assign bus.penable     = penable_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.pstrb       = pstrb_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_slverr  = rsp_slverr_q;
    assign bus.rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed self-checking bench for apb_cmd_master (TIMEOUT=4).
module tb_apb_cmd_master;
    logic pclk    = 1'b0;
    logic presetn = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    apb_cmd_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .bus     (bus)
    );

    always #5 pclk = ~pclk;

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    // Presents a command for one accept edge; returns in cycle 1 (SETUP).
    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        bus.cmd_wstrb = s;
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge pclk);
        checks++;
        if ({bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_slverr, bus.rsp_timeout} !== 6'b000000) begin
            errors++;
            $display("FAIL rst_ctrl: got %b exp 000000",
                     {bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_slverr, bus.rsp_timeout});
        end
        checks++;
        if ({bus.paddr, bus.pwdata, bus.pstrb, bus.rsp_rdata} !== 100'd0) begin
            errors++;
            $display("FAIL rst_data: got %h exp 0", {bus.paddr, bus.pwdata, bus.pstrb, bus.rsp_rdata});
        end
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_cmd_ready: got %b exp 1", bus.cmd_ready);
        end
    endtask

    task automatic test_write_zero_wait(input string tag);
        issue(1'b1, 32'h1000_0004, 32'hA5A5_0001, 4'hF);
        @(negedge pclk);
        checks++;
        if ({bus.psel, bus.penable, bus.cmd_ready} !== 3'b100) begin
            errors++;
            $display("FAIL %s_setup_ctrl: got %b exp 100", tag, {bus.psel, bus.penable, bus.cmd_ready});
        end
        checks++;
        if ({bus.paddr, bus.pwrite, bus.pwdata, bus.pstrb} !== {32'h1000_0004, 1'b1, 32'hA5A5_0001, 4'hF}) begin
            errors++;
            $display("FAIL %s_setup_bus: got %h exp %h", tag, {bus.paddr, bus.pwrite, bus.pwdata, bus.pstrb},
                     {32'h1000_0004, 1'b1, 32'hA5A5_0001, 4'hF});
        end
        step();
        bus.pready = 1'b1;
        bus.prdata = 32'h7777_7777;
        @(negedge pclk);
        checks++;
        if ({bus.psel, bus.penable, bus.rsp_valid} !== 3'b110) begin
            errors++;
            $display("FAIL %s_access: got %b exp 110", tag, {bus.psel, bus.penable, bus.rsp_valid});
        end
        step();
        bus.pready = 1'b0;
        @(negedge pclk);
        checks++;
        if ({bus.rsp_valid, bus.rsp_slverr, bus.rsp_timeout, bus.psel, bus.penable} !== 5'b10000) begin
            errors++;
            $display("FAIL %s_rsp_ctrl: got %b exp 10000", tag,
                     {bus.rsp_valid, bus.rsp_slverr, bus.rsp_timeout, bus.psel, bus.penable});
        end
        checks++;
        if (bus.rsp_rdata !== 32'h0000_0000) begin
            errors++;
            $display("FAIL %s_rsp_rdata: got %h exp 00000000", tag, bus.rsp_rdata);
        end
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        @(negedge pclk);
        checks++;
        if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin
            errors++;
            $display("FAIL %s_done: got %b exp 01", tag, {bus.rsp_valid, bus.cmd_ready});
        end
        step();
    endtask

    // ready_cyc is the cycle (1 = SETUP) in which pready is raised; 0 = never.
    task automatic test_timed(input string tag, input logic wr, input logic [31:0] a,
                              input int ready_cyc, input logic [31:0] rd,
                              input logic [31:0] exp_rdata, input logic exp_to);
        issue(wr, a, 32'h1357_9BDF, 4'hC);
        for (int c = 1; c <= 6; c++) begin
            bus.pready = (c == ready_cyc) ? 1'b1 : 1'b0;
            bus.prdata = (c == ready_cyc) ? rd : 32'hFFFF_FFFF;
            @(negedge pclk);
            if (c <= 5) begin
                checks++;
                if ({bus.psel, bus.penable, bus.paddr, bus.pwrite, bus.pwdata, bus.pstrb} !==
                    {1'b1, ((c >= 2) ? 1'b1 : 1'b0), a, wr, (wr ? 32'h1357_9BDF : 32'd0), (wr ? 4'hC : 4'h0)}) begin
                    errors++;
                    $display("FAIL %s_apb_c%0d: got %h", tag, c,
                             {bus.psel, bus.penable, bus.paddr, bus.pwrite, bus.pwdata, bus.pstrb});
                end
                checks++;
                if (bus.rsp_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_early_rsp_c%0d: got %b exp 0", tag, c, bus.rsp_valid);
                end
            end else begin
                checks++;
                if ({bus.rsp_valid, bus.rsp_slverr, bus.rsp_timeout, bus.psel, bus.penable} !==
                    {1'b1, exp_to, exp_to, 2'b00}) begin
                    errors++;
                    $display("FAIL %s_rsp_ctrl: got %b exp %b", tag,
                             {bus.rsp_valid, bus.rsp_slverr, bus.rsp_timeout, bus.psel, bus.penable},
                             {1'b1, exp_to, exp_to, 2'b00});
                end
                checks++;
                if (bus.rsp_rdata !== exp_rdata) begin
                    errors++;
                    $display("FAIL %s_rsp_rdata: got %h exp %h", tag, bus.rsp_rdata, exp_rdata);
                end
                bus.rsp_ready = 1'b1;
            end
            step();
        end
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_slverr();
        issue(1'b0, 32'h3000_0008, 32'h0, 4'h0);
        step();
        bus.pready  = 1'b1;
        bus.pslverr = 1'b1;
        bus.prdata  = 32'h1234_5678;
        step();
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
        @(negedge pclk);
        checks++;
        if ({bus.rsp_valid, bus.rsp_slverr, bus.rsp_timeout} !== 3'b110) begin
            errors++;
            $display("FAIL slverr_ctrl: got %b exp 110", {bus.rsp_valid, bus.rsp_slverr, bus.rsp_timeout});
        end
        checks++;
        if (bus.rsp_rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL slverr_rdata: got %h exp 12345678", bus.rsp_rdata);
        end
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        issue(1'b0, 32'h4000_0000, 32'h0, 4'h0);
        step();
        bus.pready = 1'b1;
        bus.prdata = 32'hCAFE_0042;
        step();
        bus.pready    = 1'b0;
        bus.prdata    = 32'h0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 32'h4000_0100;
        bus.cmd_wdata = 32'h0000_5A5A;
        bus.cmd_wstrb = 4'h3;
        for (int k = 0; k < 5; k++) begin
            @(negedge pclk);
            checks++;
            if ({bus.rsp_valid, bus.rsp_slverr, bus.rsp_timeout, bus.cmd_ready, bus.psel, bus.rsp_rdata} !==
                {5'b10000, 32'hCAFE_0042}) begin
                errors++;
                $display("FAIL bp_hold_%0d: got %h exp %h", k,
                         {bus.rsp_valid, bus.rsp_slverr, bus.rsp_timeout, bus.cmd_ready, bus.psel, bus.rsp_rdata},
                         {5'b10000, 32'hCAFE_0042});
            end
            step();
        end
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        @(negedge pclk);
        checks++;
        if ({bus.rsp_valid, bus.cmd_ready, bus.psel} !== 3'b010) begin
            errors++;
            $display("FAIL bp_release: got %b exp 010", {bus.rsp_valid, bus.cmd_ready, bus.psel});
        end
        step();
        bus.cmd_valid = 1'b0;
        @(negedge pclk);
        checks++;
        if ({bus.psel, bus.penable, bus.paddr, bus.pwrite, bus.pwdata, bus.pstrb} !==
            {2'b10, 32'h4000_0100, 1'b1, 32'h0000_5A5A, 4'h3}) begin
            errors++;
            $display("FAIL bp_next_setup: got %h", {bus.psel, bus.penable, bus.paddr, bus.pwrite, bus.pwdata, bus.pstrb});
        end
        step();
        bus.pready = 1'b1;
        step();
        bus.pready = 1'b0;
        @(negedge pclk);
        checks++;
        if ({bus.rsp_valid, bus.rsp_slverr, bus.rsp_rdata} !== {2'b10, 32'd0}) begin
            errors++;
            $display("FAIL bp_next_rsp: got %h", {bus.rsp_valid, bus.rsp_slverr, bus.rsp_rdata});
        end
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        issue(1'b0, 32'h5000_0000, 32'h0, 4'h0);
        step();
        step();
        @(negedge pclk);
        checks++;
        if ({bus.psel, bus.penable} !== 2'b11) begin
            errors++;
            $display("FAIL rmid_pre: got %b exp 11", {bus.psel, bus.penable});
        end
        #2;
        presetn = 1'b0;
        #1;
        checks++;
        if ({bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL rmid_async: got %b exp 0001", {bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready});
        end
        bus.pready = 1'b1;
        @(posedge pclk);
        @(negedge pclk);
        presetn = 1'b1;
        bus.pready = 1'b0;
        step();
        step();
        @(negedge pclk);
        checks++;
        if ({bus.psel, bus.rsp_valid, bus.cmd_ready} !== 3'b001) begin
            errors++;
            $display("FAIL rmid_after: got %b exp 001", {bus.psel, bus.rsp_valid, bus.cmd_ready});
        end
        step();
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h0;
        bus.cmd_wdata = 32'h0;
        bus.cmd_wstrb = 4'h0;
        bus.rsp_ready = 1'b0;
        bus.pready    = 1'b0;
        bus.prdata    = 32'h0;
        bus.pslverr   = 1'b0;
        test_reset();
        @(negedge pclk);
        presetn = 1'b1;
        step();
        test_write_zero_wait("wr0");
        test_timed("rd3w", 1'b0, 32'h2000_0010, 5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
        test_slverr();
        test_timed("tmo", 1'b0, 32'h2000_0020, 0, 32'h0, 32'h0, 1'b1);
        test_timed("tmo_rdy", 1'b1, 32'h2000_0030, 5, 32'hFFFF_FFFF, 32'h0, 1'b0);
        test_backpressure();
        test_reset_mid();
        test_write_zero_wait("wr_post_rst");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
